nios2_camera_sdram_lcd_cpu_oci_dct_packer: RTL and testbench
============================================================

Name: nios2_camera_sdram_lcd_cpu_oci_dct_packer

Overview:
- Producer side of the OCI data-trace frame interface: packs 2-bit trace symbols into 30-bit frames (up to 15 symbols) and presents them as dct_buffer/dct_count to the frame consumer (OCI test bench / trace sink).
- Sits between the CPU data-trace symbol generator and the trace frame sink.
- Provides a one-frame output holding register with valid/ready handshake, explicit and timeout-driven flush of partial frames, and backpressure to the symbol source.

Parameters:
- FLUSH_TIMEOUT, 64, idle cycles with a partial frame before auto-flush; 0 disables auto-flush.
- DROP_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- sym_valid  in  1  symbol offered.
- sym_data  in  2  trace symbol.
- sym_ready  out  1  symbol accepted when sym_valid && sym_ready.
- flush  in  1  one-cycle request to emit the partial frame.
- test_ending  in  1  level; while high, behaves as continuous flush.
- dct_valid  out  1  output frame valid.
- dct_ready  in  1  consumer accepts the frame when dct_valid && dct_ready.
- dct_buffer  out  30  packed frame; oldest symbol in the highest occupied slot; unused upper bits zero.
- dct_count  out  4  symbols in frame, 1..15 when dct_valid.
- stall_cnt  out  DROP_CNT_W  optional stall counter (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0):
  - dct_valid=0, dct_buffer=0, dct_count=0, sym_ready=1, stall_cnt=0.
  - Accumulator, counters and flush_pending cleared; state EMPTY.
  - Reset mid-frame discards accumulator and holding-register contents.
- Accumulator acc[29:0], acc_cnt 0..15.
  - Accept: acc <= {acc[27:0], sym_data}, acc_cnt+1. The new symbol goes in bits [1:0].
- Transfer acc -> holding register. Condition: output free, i.e. !dct_valid || dct_ready this cycle.
  - On transfer: dct_buffer <= acc including any symbol accepted this cycle; dct_count <= resulting count; dct_valid <= 1; acc/acc_cnt cleared; flush_pending cleared.
  - Latency: a symbol completing a frame appears on dct_buffer the next cycle.
- States:
  - EMPTY (acc_cnt=0): accept -> FILL.
  - FILL (1..14):
    - Accept making count 15 -> transfer if output free, else -> HOLD.
    - Flush/timeout -> transfer if output free, else set flush_pending -> HOLD.
  - HOLD (frame complete or flush pending, output busy):
    - sym_ready=0 only when acc_cnt=15. With a pending flush at <15, symbols are still accepted and included in the frame.
    - Output frees -> transfer -> EMPTY.
- sym_ready=0 iff acc_cnt=15. Otherwise 1.
- Simultaneous accept + flush: symbol is included in the flushed frame.
- Flush/test_ending with acc_cnt=0 and no accept: no frame, no pending.
- Consumer pop and transfer in the same cycle: new frame loaded, dct_valid stays 1.
- Timeout: idle counter counts cycles with 0<acc_cnt<15 and no accept; cleared on accept or transfer; reaching FLUSH_TIMEOUT acts as flush.
- Frames are never dropped or reordered; dct_buffer/dct_count stable while dct_valid && !dct_ready.

Optional Feature:
- Macro OCI_DCT_STALL_CNT_EN.
- Defined: stall_cnt increments (saturating at all-ones) each cycle sym_valid && !sym_ready; cleared only by reset.
- Undefined: stall_cnt tied to 0, no counter logic.

Test Plan:
- 15 symbols 2'b11,2'b10,... back-to-back, dct_ready=1 -> one frame, dct_count=15, dct_buffer[29:28]=2'b11 (first), [1:0]=last, dct_valid one cycle after 15th accept.
- Symbols 1,2,3 then flush -> dct_count=3, dct_buffer=30'h1B; 3rd symbol with flush same cycle gives same result.
- dct_ready=0, push 30 symbols -> first frame held stable, second accumulates to 15, sym_ready=0; release dct_ready -> frames emitted in order, no loss; stall_cnt counts stalled cycles when macro defined, 0 when not.
- FLUSH_TIMEOUT=4, push 2 symbols then idle -> frame dct_count=2 on 5th idle cycle; flush with empty acc -> no dct_valid.
- Assert reset_n low mid-frame with dct_valid=1 -> all outputs to reset values asynchronously; subsequent symbols start fresh frame, count from 1.

Source files
------------

// File: rtl/nios2_camera_sdram_lcd_cpu_oci_dct_packer.sv
// OCI data-trace packer: collects 2-bit symbols into 30-bit frames behind a one-frame holding register.
// Define OCI_DCT_STALL_CNT_EN to build the saturating source-stall counter on stall_cnt.
module nios2_camera_sdram_lcd_cpu_oci_dct_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 64,
  parameter int unsigned DROP_CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sym_valid,
  input  logic [1:0]            sym_data,
  output logic                  sym_ready,
  input  logic                  flush,
  input  logic                  test_ending,
  output logic                  dct_valid,
  input  logic                  dct_ready,
  output logic [29:0]           dct_buffer,
  output logic [3:0]            dct_count,
  output logic [DROP_CNT_W-1:0] stall_cnt
);

  localparam int unsigned IW = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {EMPTY, FILL, HOLD} state_t;

  state_t        state;
  logic [29:0]   acc;
  logic [3:0]    acc_cnt;
  logic          flush_pending;
  logic [IW-1:0] idle_cnt;

  logic          accept;
  logic [29:0]   acc_nxt;
  logic [3:0]    cnt_nxt;
  logic          idle;
  logic          timeout_hit;
  logic          flush_req;
  logic          want;
  logic          xfer;

  // The symbol accepted this cycle is folded in before deciding on a transfer,
  // so a completing or flush-coincident symbol lands in the outgoing frame.
  always_comb begin
    accept      = sym_valid && sym_ready;
    acc_nxt     = accept ? {acc[27:0], sym_data} : acc;
    cnt_nxt     = acc_cnt + {3'b000, accept};
    idle        = (state != EMPTY) && (acc_cnt != 4'd15) && !accept;
    timeout_hit = (FLUSH_TIMEOUT != 0) && idle && (idle_cnt == IDLE_MAX);
    flush_req   = flush || test_ending || timeout_hit;
    want        = (cnt_nxt != 4'd0) && ((cnt_nxt == 4'd15) || flush_req || flush_pending);
    xfer        = want && (!dct_valid || dct_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= EMPTY;
      acc           <= '0;
      acc_cnt       <= '0;
      flush_pending <= 1'b0;
      idle_cnt      <= '0;
      sym_ready     <= 1'b1;
      dct_valid     <= 1'b0;
      dct_buffer    <= '0;
      dct_count     <= '0;
    end else if (xfer) begin
      state         <= EMPTY;
      acc           <= '0;
      acc_cnt       <= '0;
      flush_pending <= 1'b0;
      idle_cnt      <= '0;
      sym_ready     <= 1'b1;
      dct_valid     <= 1'b1;
      dct_buffer    <= acc_nxt;
      dct_count     <= cnt_nxt;
    end else begin
      acc       <= acc_nxt;
      acc_cnt   <= cnt_nxt;
      sym_ready <= (cnt_nxt != 4'd15);
      if (dct_valid && dct_ready)
        dct_valid <= 1'b0;
      if (want && flush_req)
        flush_pending <= 1'b1;
      if (accept)
        idle_cnt <= '0;
      else if (idle && (idle_cnt != IDLE_MAX))
        idle_cnt <= idle_cnt + IW'(1);
      if (cnt_nxt == 4'd0)
        state <= EMPTY;
      else if (want)
        state <= HOLD;
      else
        state <= FILL;
    end
  end

`ifdef OCI_DCT_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (sym_valid && !sym_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + DROP_CNT_W'(1);
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nios2_camera_sdram_lcd_cpu_oci_dct_packer.sv
// Bench for the OCI trace packer: directed table, hand sequences and a queue-level random model.
module tb_nios2_camera_sdram_lcd_cpu_oci_dct_packer;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sym_valid, flush, test_ending, dct_ready;
  logic [1:0]  sym_data;
  logic        sym_ready, dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [15:0] stall_cnt;

  nios2_camera_sdram_lcd_cpu_oci_dct_packer #(.FLUSH_TIMEOUT(TO), .DROP_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .flush(flush), .test_ending(test_ending),
    .dct_valid(dct_valid), .dct_ready(dct_ready), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: symbol queues for the accumulator and the held frame.
  logic [1:0] macc[$];
  logic [1:0] mframe[$];
  bit         mvalid, mpend;
  int         midle;
  int         mstall;

  function automatic logic [29:0] pack(input logic [1:0] q[$]);
    logic [29:0] b = '0;
    foreach (q[i]) b = (b << 2) | 30'(q[i]);
    return b;
  endfunction

  task automatic model_reset();
    macc.delete(); mframe.delete();
    mvalid = 0; mpend = 0; midle = 0; mstall = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] d, input bit fl, input bit te, input bit rdy);
    int  sz  = macc.size();
    bit  ok  = v && (sz < 15);
    bit  idl = (sz > 0) && (sz < 15) && !ok;
    bit  to, freq, want;
    if (v && !ok && mstall != 16'hffff) mstall++;
    if (ok) macc.push_back(d);
    to   = (TO > 0) && idl && (midle + 1 >= TO);
    freq = fl || te || to;
    want = (macc.size() > 0) && (macc.size() == 15 || freq || mpend);
    if (want && (!mvalid || rdy)) begin
      mframe = macc; macc.delete();
      mvalid = 1; mpend = 0; midle = 0;
    end else begin
      if (mvalid && rdy) mvalid = 0;
      if (want && freq) mpend = 1;
      if (ok) midle = 0;
      else if (idl) midle++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] es;
`ifdef OCI_DCT_STALL_CNT_EN
    es = 16'(mstall);
`else
    es = '0;
`endif
    chk("m_sym_ready", 32'(sym_ready), 32'(macc.size() != 15));
    chk("m_dct_valid", 32'(dct_valid), 32'(mvalid));
    if (mvalid) begin
      chk("m_dct_count", 32'(dct_count), 32'(mframe.size()));
      chk("m_dct_buffer", 32'(dct_buffer), 32'(pack(mframe)));
    end
    chk("m_stall_cnt", 32'(stall_cnt), 32'(es));
  endtask

  task automatic cyc(input bit v, input logic [1:0] d, input bit fl, input bit te, input bit rdy);
    @(negedge clk);
    sym_valid = v; sym_data = d; flush = fl; test_ending = te; dct_ready = rdy;
    model_step(v, d, fl, te, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drain();
    repeat (3) cyc(0, 2'b00, 1, 0, 1);
  endtask

  typedef struct {
    bit v; logic [1:0] d; bit fl; bit te; bit rdy;
    bit ev; logic [3:0] ec; logic [29:0] eb; bit esr;
  } vec_t;

  vec_t tbl[13];
  logic [1:0]  syms[$];
  logic [29:0] e1, e2;
  logic [15:0] exp_stall;

  initial begin
    tbl[0]  = '{1, 2'd1, 0, 0, 1, 0, 4'd0, 30'h0,  1};
    tbl[1]  = '{1, 2'd2, 0, 0, 1, 0, 4'd0, 30'h0,  1};
    tbl[2]  = '{1, 2'd3, 1, 0, 1, 1, 4'd3, 30'h1B, 1};
    tbl[3]  = '{0, 2'd0, 0, 0, 1, 0, 4'd0, 30'h0,  1};
    tbl[4]  = '{1, 2'd1, 0, 0, 1, 0, 4'd0, 30'h0,  1};
    tbl[5]  = '{1, 2'd2, 0, 0, 1, 0, 4'd0, 30'h0,  1};
    tbl[6]  = '{1, 2'd3, 0, 0, 1, 0, 4'd0, 30'h0,  1};
    tbl[7]  = '{0, 2'd0, 1, 0, 1, 1, 4'd3, 30'h1B, 1};
    tbl[8]  = '{0, 2'd0, 0, 0, 1, 0, 4'd0, 30'h0,  1};
    tbl[9]  = '{0, 2'd0, 1, 0, 1, 0, 4'd0, 30'h0,  1};
    tbl[10] = '{0, 2'd0, 0, 1, 1, 0, 4'd0, 30'h0,  1};
    tbl[11] = '{1, 2'd2, 0, 1, 1, 1, 4'd1, 30'h2,  1};
    tbl[12] = '{0, 2'd0, 0, 0, 1, 0, 4'd0, 30'h0,  1};

    reset_n = 0; sym_valid = 0; sym_data = 0; flush = 0; test_ending = 0; dct_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(dct_valid), 0);
    chk("rst_ready", 32'(sym_ready), 1);
    chk("rst_buffer", 32'(dct_buffer), 0);
    chk("rst_count", 32'(dct_count), 0);
    @(negedge clk); reset_n = 1;

    // 15 back-to-back symbols form one full frame
    e1 = '0;
    for (int i = 0; i < 15; i++) begin
      cyc(1, 2'(3 - (i % 4)), 0, 0, 1);
      e1 = (e1 << 2) | 30'(3 - (i % 4));
      if (i < 14) chk("full_early_valid", 32'(dct_valid), 0);
    end
    chk("full_valid", 32'(dct_valid), 1);
    chk("full_count", 32'(dct_count), 15);
    chk("full_first", 32'(dct_buffer[29:28]), 3);
    chk("full_last", 32'(dct_buffer[1:0]), 1);
    chk("full_buffer", 32'(dct_buffer), 32'(e1));
    drain();

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].te, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(dct_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_sym_ready", i), 32'(sym_ready), 32'(tbl[i].esr));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_count", i), 32'(dct_count), 32'(tbl[i].ec));
        chk($sformatf("tbl%0d_buffer", i), 32'(dct_buffer), 32'(tbl[i].eb));
      end
    end
    drain();

    // Backpressure: first frame held, second fills, source stalls two cycles
    syms.delete();
    for (int i = 0; i < 32; i++) begin
      logic [1:0] d = 2'($urandom);
      if (i < 30) syms.push_back(d);
      cyc(1, d, 0, 0, 0);
      if (i == 14) e1 = pack(syms);
      if (i >= 14) begin
        chk("bp_hold_valid", 32'(dct_valid), 1);
        chk("bp_hold_buffer", 32'(dct_buffer), 32'(e1));
      end
    end
    e2 = '0;
    for (int i = 15; i < 30; i++) e2 = (e2 << 2) | 30'(syms[i]);
    chk("bp_sym_ready", 32'(sym_ready), 0);
`ifdef OCI_DCT_STALL_CNT_EN
    exp_stall = 16'd2;
`else
    exp_stall = 16'd0;
`endif
    chk("bp_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    cyc(0, 2'b00, 0, 0, 1);
    chk("bp_second_valid", 32'(dct_valid), 1);
    chk("bp_second_buffer", 32'(dct_buffer), 32'(e2));
    chk("bp_second_count", 32'(dct_count), 15);
    cyc(0, 2'b00, 0, 0, 1);
    chk("bp_empty", 32'(dct_valid), 0);
    drain();

    // Idle timeout on a two-symbol partial frame
    cyc(1, 2'd2, 0, 0, 1);
    cyc(1, 2'd1, 0, 0, 1);
    for (int j = 1; j <= 4; j++) begin
      cyc(0, 2'b00, 0, 0, 1);
      chk($sformatf("to_idle%0d_valid", j), 32'(dct_valid), 32'(j == 4));
    end
    chk("to_count", 32'(dct_count), 2);
    chk("to_buffer", 32'(dct_buffer), 32'h9);
    cyc(0, 2'b00, 0, 0, 1);
    cyc(0, 2'b00, 1, 0, 1);
    chk("to_empty_flush", 32'(dct_valid), 0);

    // Asynchronous reset with a held frame and a partial accumulator
    for (int i = 0; i < 18; i++) cyc(1, 2'($urandom), 0, 0, 0);
    chk("ar_pre_valid", 32'(dct_valid), 1);
    @(negedge clk);
    sym_valid = 0; flush = 0; test_ending = 0; dct_ready = 0;
    #2 reset_n = 0;
    #1;
    model_reset();
    chk("ar_valid", 32'(dct_valid), 0);
    chk("ar_buffer", 32'(dct_buffer), 0);
    chk("ar_count", 32'(dct_count), 0);
    chk("ar_sym_ready", 32'(sym_ready), 1);
    chk("ar_stall", 32'(stall_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1;
    cyc(1, 2'd3, 1, 0, 1);
    chk("ar_fresh_count", 32'(dct_count), 1);
    chk("ar_fresh_buffer", 32'(dct_buffer), 3);

    // Randomised traffic against the queue model
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 40) == 0), ($urandom_range(0, 9) < 6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
